// File: rtl/pipeline_fetch_queue.sv
// Instruction fetch front-end: credit-limited requests to a fixed
// 1-cycle-latency memory, buffered in a small FIFO ahead of decode.
`timescale 1ns/1ps
module pipeline_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] INC      = XLEN'(4)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ifl_pc_q, ifl_pc_d;
    logic            ifl_q, ifl_d;
    logic            boot_q, boot_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;

    logic [XLEN-1:0] mem_pc    [DEPTH];
    logic [XLEN-1:0] mem_instr [DEPTH];

    logic [CW:0] used;
    logic        push;
    logic        pop;

    assign out_valid = (count_q != '0);
    assign out_pc    = mem_pc[head_q];
    assign out_instr = mem_instr[head_q];

    // A redirect flushes everything, so it always sees the full credit.
    always_comb begin
        used = '0;
        if (!redirect) begin
            used = {1'b0, count_q} + (CW + 1)'(ifl_q);
        end
        imem_req  = !boot_q && (used < (CW + 1)'(DEPTH));
        imem_addr = redirect ? redirect_target : pc_q;
        push      = ifl_q && !redirect;
        pop       = out_valid && out_ready && !redirect;
    end

    always_comb begin
        pc_d     = imem_req ? imem_addr + INC : imem_addr;
        ifl_d    = imem_req;
        ifl_pc_d = imem_addr;
        boot_d   = 1'b0;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        unique case (1'b1)
            redirect: begin
                count_d = '0;
                head_d  = '0;
                tail_d  = '0;
            end
            push && !pop: begin
                count_d = count_q + 1'b1;
                tail_d  = tail_q + 1'b1;
            end
            pop && !push: begin
                count_d = count_q - 1'b1;
                head_d  = head_q + 1'b1;
            end
            push && pop: begin
                tail_d = tail_q + 1'b1;
                head_d = head_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ifl_q    <= 1'b0;
            ifl_pc_q <= RESET_PC;
            boot_q   <= 1'b1;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            ifl_q    <= ifl_d;
            ifl_pc_q <= ifl_pc_d;
            boot_q   <= boot_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    // Payload storage carries no reset; validity lives in count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_q]    <= ifl_pc_q;
            mem_instr[tail_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Bench for pipeline_fetch_queue: queue-based reference model plus
// directed cold-start, stall, redirect, wrap and async-reset scenarios.
`timescale 1ns/1ps
module tb_pipeline_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] INC      = 32'h4;

    logic        clk;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    bit          m_ifl;
    logic [31:0] m_ifl_pc;
    logic [31:0] stream_exp;
    logic [31:0] popped[$];
    int          req_cnt;

    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_instr;

    pipeline_fetch_queue #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC),
        .INC(INC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    always @(posedge clk)
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hdead_beef;

    task automatic model_reset();
        m_boot     = 1'b1;
        m_pc       = RESET_PC;
        m_q.delete();
        m_ifl      = 1'b0;
        m_ifl_pc   = RESET_PC;
        stream_exp = RESET_PC;
        popped.delete();
        req_cnt    = 0;
    endtask

    // Leaves reset released at a falling edge: the next step is the boot cycle.
    task automatic do_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    // One cycle: drive at the falling edge, compare, then advance the model.
    task automatic step(input bit rd, input logic [31:0] tgt, input bit rdy);
        bit          e_req;
        logic [31:0] e_addr;
        int          used;
        bit          pop;
        redirect        = rd;
        redirect_target = tgt;
        out_ready       = rdy;
        #1;
        used   = rd ? 0 : m_q.size() + int'(m_ifl);
        e_req  = !m_boot && (used < DEPTH);
        e_addr = rd ? tgt : m_pc;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = out_valid;
        obs_pc    = out_pc;
        obs_instr = out_instr;
        n_checks++;
        if (imem_req !== e_req) begin
            n_fail++;
            $display("FAIL imem_req: got %b want %b t=%0t", imem_req, e_req, $time);
        end
        n_checks++;
        if (imem_addr !== e_addr) begin
            n_fail++;
            $display("FAIL imem_addr: got %h want %h t=%0t", imem_addr, e_addr, $time);
        end
        n_checks++;
        if (out_valid !== (m_q.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid: got %b want %b t=%0t", out_valid,
                     m_q.size() != 0, $time);
        end
        if (m_q.size() != 0) begin
            n_checks++;
            if (out_pc !== m_q[0] || out_instr !== mem_word(m_q[0])) begin
                n_fail++;
                $display("FAIL head: got pc %h instr %h want pc %h instr %h t=%0t",
                         out_pc, out_instr, m_q[0], mem_word(m_q[0]), $time);
            end
        end
        pop = !rd && (m_q.size() != 0) && rdy;
        if (imem_req === 1'b1) req_cnt++;
        if (pop) begin
            popped.push_back(out_pc);
            n_checks++;
            if (out_pc !== stream_exp) begin
                n_fail++;
                $display("FAIL order: got pc %h want %h t=%0t", out_pc, stream_exp, $time);
            end
            stream_exp = stream_exp + INC;
        end
        @(posedge clk);
        if (rd) begin
            m_q.delete();
            stream_exp = tgt;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_ifl) m_q.push_back(m_ifl_pc);
        end
        m_ifl    = e_req;
        m_ifl_pc = e_addr;
        m_pc     = e_req ? e_addr + INC : e_addr;
        m_boot   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        redirect_target = 32'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_values: got req %b valid %b addr %h want 0 0 %h",
                     imem_req, out_valid, imem_addr, RESET_PC);
        end
        @(negedge clk);
    endtask

    task automatic test_cold_start();
        do_reset();
        step(0, 0, 1);
        n_checks++;
        if (obs_req !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_no_req: got %b want 0", obs_req);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: got req %b addr %h want 1 %h", obs_req, obs_addr, RESET_PC);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: got valid %b want 0", obs_valid);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h0 || obs_instr !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL first_out: got valid %b pc %h instr %h want 1 0 %h",
                     obs_valid, obs_pc, obs_instr, mem_word(32'h0));
        end
        step(0, 0, 1);
        step(0, 0, 1);
        n_checks++;
        if (popped.size() != 3 || popped[1] !== 32'h4 || popped[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL stream: got %0d pops want 3 (0,4,8)", popped.size());
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        repeat (10) step(0, 0, 0);
        n_checks++;
        if (req_cnt != DEPTH || obs_req !== 1'b0 || obs_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL stall_full: got reqs %0d req %b pc %h want %0d 0 0",
                     req_cnt, obs_req, obs_pc, DEPTH);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_req !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_before_pop: got req %b want 0", obs_req);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL resume: got req %b addr %h want 1 00000010", obs_req, obs_addr);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        n_checks++;
        if (popped.size() != 4 || popped[0] !== 32'h0 || popped[3] !== 32'hc) begin
            n_fail++;
            $display("FAIL drain: got %0d pops want 4 (0..c)", popped.size());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 20 && !(m_q.size() == 3 && m_ifl); i++) step(0, 0, 0);
        n_checks++;
        if (!(m_q.size() == 3 && m_ifl)) begin
            n_fail++;
            $display("FAIL redirect_setup: got count %0d ifl %b want 3 1", m_q.size(), m_ifl);
        end
        step(1, 32'h100, 1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_req: got req %b addr %h want 1 00000100", obs_req, obs_addr);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got valid %b want 0", obs_valid);
        end
        step(0, 0, 1);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL redirect_out: got valid %b pc %h want 1 00000100", obs_valid, obs_pc);
        end
        repeat (6) step(0, 0, 1);
    endtask

    task automatic test_back_to_back();
        step(1, 32'h200, 1);
        step(1, 32'h300, 1);
        popped.delete();
        repeat (6) step(0, 0, 1);
        n_checks++;
        if (popped.size() < 2 || popped[0] !== 32'h300 || popped[1] !== 32'h304) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d pops first %h want 300,304",
                     popped.size(), popped.size() > 0 ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_wrap();
        step(1, 32'hffff_fffc, 1);
        popped.delete();
        repeat (5) step(0, 0, 1);
        n_checks++;
        if (popped.size() < 2 || popped[0] !== 32'hffff_fffc || popped[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: got %0d pops first %h want fffffffc,00000000",
                     popped.size(), popped.size() > 0 ? popped[0] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 20 && m_q.size() != 2; i++) step(0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_reset: got req %b valid %b addr %h want 0 0 %h",
                     imem_req, out_valid, imem_addr, RESET_PC);
        end
        @(negedge clk);
        model_reset();
        reset = 1'b1;
        step(0, 0, 1);
        step(0, 0, 1);
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart: got req %b addr %h want 1 %h", obs_req, obs_addr, RESET_PC);
        end
        step(0, 0, 1);
        step(0, 0, 1);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL restart_out: got valid %b pc %h want 1 %h", obs_valid, obs_pc, RESET_PC);
        end
    endtask

    task automatic test_random();
        bit          rd;
        bit          rdy;
        logic [31:0] tgt;
        do_reset();
        repeat (1500) begin
            rd  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = $urandom & 32'hffff_fffc;
            step(rd, tgt, rdy);
        end
        n_checks++;
        if (popped.size() < 100) begin
            n_fail++;
            $display("FAIL throughput: got %0d pops want >= 100", popped.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        imem_rdata = 32'h0;
        test_reset();
        test_cold_start();
        test_stall_full();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
